cmd_dispatch: RTL
=================

Name: cmd_dispatch

Overview:
Initiator side of the SysState/Enable/Done sub-state-machine handshake. Accepts a 16-bit command word from the host-link receiver, validates it, presents it on SysState, asserts Enable, and waits for the selected sub-SM's Done. It then completes the four-phase release and reports a one-byte response code to the host link. Sits between the com-port receive path and all command sub-SMs, including the comm-port test sub-SM, which is command 16'h0001.

Parameters:
NUM_SUB, 4, number of sub-SMs; valid commands are 16'h0001..NUM_SUB, and command k owns DoneVec[k-1]
TMO_W, 16, width of the handshake timeout counter
TIMEOUT, 16'd50000, cycles allowed in WAIT_DONE, and separately in RELEASE, before abort

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous reset, active-high
CmdWord  in  16  command from host-link receiver
CmdValid  in  1  CmdWord valid
CmdReady  out  1  dispatcher can accept; equals (state==IDLE)
SysState  out  16  command broadcast to sub-SMs; 16'h0000 = idle
Enable  out  1  handshake request to sub-SMs
DoneVec  in  NUM_SUB  Done from each sub-SM
RespValid  out  1  one-cycle pulse; RespCode valid
RespCode  out  8  8'hA0 ok, 8'hE1 bad command, 8'hE2 done timeout, 8'hE3 release timeout, 8'hE4 stale Done
Busy  out  1  state != IDLE

Behaviour:
- Reset (Rst=1 at a Clk edge, synchronous): state IDLE, SysState=0, Enable=0, RespValid=0, RespCode=0, timer=0.
- Reset mid-operation: same values. Enable drops on that edge. No response is issued for the aborted command.
- All outputs are registered except CmdReady and Busy, which are decoded from the state.
- idx = CmdWord-1, latched at accept.
- IDLE: on CmdValid & CmdReady:
  - If 1 <= CmdWord <= NUM_SUB: SysState<=CmdWord, latch idx, go ISSUE.
  - Otherwise (including 16'h0000): RespValid<=1, RespCode<=E1, stay IDLE.
- ISSUE (SysState is stable for one cycle before Enable rises):
  - If DoneVec[idx]=1 (stale): RespCode<=E4, go RELEASE without asserting Enable.
  - Else: Enable<=1, timer<=0, go WAIT_DONE.
- WAIT_DONE: timer increments each cycle.
  - DoneVec[idx]=1: Enable<=0, RespCode<=A0, timer<=0, go RELEASE.
  - Else if timer==TIMEOUT-1: Enable<=0, RespCode<=E2, timer<=0, go RELEASE.
  - DoneVec bits other than idx are ignored.
- RELEASE: timer increments each cycle.
  - DoneVec[idx]=0: SysState<=0, RespValid<=1, go IDLE.
  - Else if timer==TIMEOUT-1: RespCode<=E3, SysState<=0, RespValid<=1, go IDLE.
  - Done and timeout in the same cycle: Done wins.
- RespValid is high for exactly one cycle.
- RespCode holds its value until the next response.
- Latency with a responder that registers Done one edge after Enable:
  - Accept at edge e0; SysState valid after e0; Enable high after e1.
  - Done seen at e3, Enable low after e3.
  - Done low seen at e5; RespValid high in the cycle after e5.
  - Total: 6 edges from accept to response.
- CmdValid while Busy: not accepted (CmdReady=0); the upstream holds the word.
- Back-to-back commands: the next command is accepted in the cycle RespValid is high, provided CmdValid is present. Enable is guaranteed low for at least 2 cycles between commands.
- Timer saturates. TIMEOUT=0 is illegal; the implementation treats it as 1.

Decomposition:
- Shared package:
  - Command code constants: TestCom=16'h0001, plus codes for the other sub-SMs.
  - Idle code 16'h0000.
  - Response codes A0/E1/E2/E3/E4.
  - State encoding localparams.
- Sub-SMs include the same command constants.
- No sub-module needed; the timeout counter stays inline (about 150 lines RTL).

Test Plan:
- Reset, then CmdWord=16'h0001 with a responder model raising DoneVec[0] one edge after Enable and dropping it one edge after Enable falls → Enable high 2 cycles, SysState=0001 throughout, RespValid pulse with RespCode=A0 on edge 6 after accept, SysState back to 0.
- CmdWord=16'h0000, then 16'h0005 with NUM_SUB=4 → RespValid next cycle with E1 each time; Enable never asserted; CmdReady stays 1.
- CmdWord=16'h0002 with DoneVec[1] held low, TIMEOUT=8 → Enable falls after 8 WAIT_DONE cycles; RespCode=E2 one cycle later.
- DoneVec[2] stuck high before CmdWord=16'h0003 → no Enable pulse; RELEASE times out; RespCode=E3. Repeat with Done released during RELEASE → E4.
- Rst asserted while in WAIT_DONE → next cycle Enable=0, SysState=0, RespValid=0, CmdReady=1; following command 16'h0001 completes with A0.
- Two back-to-back valid commands, 0001 then 0002, with CmdValid held → second accepted in the RespValid cycle of the first; Enable low for at least 2 cycles between commands; both return A0.

Source files
------------

// File: rtl/cmd_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_dispatch_pkg
// Description : Command codes, response codes and state encoding shared by the
//               command dispatcher and the sub-state-machines it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_dispatch_pkg;

   localparam logic [15:0] c_cmd_idle     = 16'h0000;
   localparam logic [15:0] c_cmd_test_com = 16'h0001;
   localparam logic [15:0] c_cmd_sub2     = 16'h0002;
   localparam logic [15:0] c_cmd_sub3     = 16'h0003;
   localparam logic [15:0] c_cmd_sub4     = 16'h0004;

   localparam logic [7:0] c_resp_ok       = 8'hA0;
   localparam logic [7:0] c_resp_bad_cmd  = 8'hE1;
   localparam logic [7:0] c_resp_done_tmo = 8'hE2;
   localparam logic [7:0] c_resp_rel_tmo  = 8'hE3;
   localparam logic [7:0] c_resp_stale    = 8'hE4;

   localparam logic [1:0] c_st_idle      = 2'd0;
   localparam logic [1:0] c_st_issue     = 2'd1;
   localparam logic [1:0] c_st_wait_done = 2'd2;
   localparam logic [1:0] c_st_release   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE      = c_st_idle,
      S_ISSUE     = c_st_issue,
      S_WAIT_DONE = c_st_wait_done,
      S_RELEASE   = c_st_release
   } state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : cmd_dispatch
// Description : Initiator of the SysState/Enable/Done four-phase handshake;
//               validates host commands and reports a one-byte response code.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_dispatch
   import cmd_dispatch_pkg::*;
#(
   parameter int          NUM_SUB = 4,
   parameter int          TMO_W   = 16,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [15:0]        CmdWord,
   input  logic               CmdValid,
   output logic               CmdReady,
   output logic [15:0]        SysState,
   output logic               Enable,
   input  logic [NUM_SUB-1:0] DoneVec,
   output logic               RespValid,
   output logic [7:0]         RespCode,
   output logic               Busy
);

   localparam int IDX_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
   localparam logic [15:0] c_max_cmd = 16'(NUM_SUB);
   // A zero timeout would never match; it behaves like a one-cycle timeout.
   localparam logic [TMO_W-1:0] c_tmo_last = (TIMEOUT <= 1) ? '0 : TMO_W'(TIMEOUT - 1);

   state_t            r_state, w_state_nxt;
   logic [15:0]       r_sys_state, w_sys_state_nxt;
   logic              r_enable, w_enable_nxt;
   logic              r_resp_valid, w_resp_valid_nxt;
   logic [7:0]        r_resp_code, w_resp_code_nxt;
   logic [TMO_W-1:0]  r_timer, w_timer_nxt, w_timer_inc;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic              w_done, w_tmo, w_cmd_ok;

   assign w_done      = DoneVec[r_idx];
   assign w_tmo       = (r_timer == c_tmo_last);
   assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + TMO_W'(1);
   assign w_cmd_ok    = (CmdWord != c_cmd_idle) && (CmdWord <= c_max_cmd);

   assign CmdReady  = (r_state == S_IDLE);
   assign Busy      = (r_state != S_IDLE);
   assign SysState  = r_sys_state;
   assign Enable    = r_enable;
   assign RespValid = r_resp_valid;
   assign RespCode  = r_resp_code;

   always_comb begin
      w_state_nxt      = r_state;
      w_sys_state_nxt  = r_sys_state;
      w_enable_nxt     = r_enable;
      w_resp_valid_nxt = 1'b0;
      w_resp_code_nxt  = r_resp_code;
      w_timer_nxt      = r_timer;
      w_idx_nxt        = r_idx;
      case (r_state)
         S_IDLE: begin
            w_timer_nxt = '0;
            if (CmdValid) begin
               if (w_cmd_ok) begin
                  w_sys_state_nxt = CmdWord;
                  w_idx_nxt       = IDX_W'(CmdWord - 16'd1);
                  w_state_nxt     = S_ISSUE;
               end else begin
                  w_resp_valid_nxt = 1'b1;
                  w_resp_code_nxt  = c_resp_bad_cmd;
               end
            end
         end
         S_ISSUE: begin
            w_timer_nxt = '0;
            // Done already high means the responder never released the last
            // handshake; skip Enable and only wait for it to drop.
            if (w_done) begin
               w_resp_code_nxt = c_resp_stale;
               w_state_nxt     = S_RELEASE;
            end else begin
               w_enable_nxt = 1'b1;
               w_state_nxt  = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            w_timer_nxt = w_timer_inc;
            if (w_done || w_tmo) begin
               w_enable_nxt    = 1'b0;
               w_resp_code_nxt = w_done ? c_resp_ok : c_resp_done_tmo;
               w_timer_nxt     = '0;
               w_state_nxt     = S_RELEASE;
            end
         end
         S_RELEASE: begin
            w_timer_nxt = w_timer_inc;
            if (!w_done || w_tmo) begin
               if (w_done) begin
                  w_resp_code_nxt = c_resp_rel_tmo;
               end
               w_sys_state_nxt  = c_cmd_idle;
               w_resp_valid_nxt = 1'b1;
               w_timer_nxt      = '0;
               w_state_nxt      = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state      <= S_IDLE;
         r_sys_state  <= c_cmd_idle;
         r_enable     <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_code  <= 8'h00;
         r_timer      <= '0;
         r_idx        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_sys_state  <= w_sys_state_nxt;
         r_enable     <= w_enable_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_code  <= w_resp_code_nxt;
         r_timer      <= w_timer_nxt;
         r_idx        <= w_idx_nxt;
      end
   end

endmodule
`default_nettype wire
